// File: rtl/dc_ascii_hex_parser_if.sv
// Stream interface for the ASCII hex parser.
// Input side : in_data/in_valid from producer, in_ready back to producer.
// Output side: out_data/out_ndig/out_err/out_valid to consumer, out_ready back.
// master: the environment (producer + consumer); slave: the parser itself.
interface dc_ascii_hex_parser_if #(
  parameter int unsigned NDIG = 8
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [4*NDIG-1:0] out_data;
  logic [4:0]        out_ndig;
  logic [1:0]        out_err;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ndig, out_err, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_ndig, out_err, out_valid
  );
endinterface

// File: rtl/dc_ascii_hex_parser.sv
// ASCII hex word parser. Accepts a character stream, accumulates up to NDIG hex
// digits (optional 0x/0X prefix) and emits one word per terminator
// (space, CR, LF, comma). Errors: 01 invalid char, 10 overflow, 11 prefix only.
// Ports:
//   clk   - clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - slave side of dc_ascii_hex_parser_if (character in, word out)
module dc_ascii_hex_parser #(
  parameter int unsigned NDIG = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  dc_ascii_hex_parser_if.slave bus
);
  localparam int unsigned W    = 4 * NDIG;
  localparam logic [4:0]  NdigW = 5'(NDIG);

  typedef enum logic [1:0] {StIdle, StAccum, StDiscard, StEmit} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [4:0]     cnt_q, cnt_d;
  logic           pfx_q, pfx_d;
  logic [1:0]     err_q, err_d;
  logic [W-1:0]   odata_q, odata_d;
  logic [4:0]     ondig_q, ondig_d;
  logic [1:0]     oerr_q, oerr_d;
  logic           ovalid_q, ovalid_d;

  logic           in_ready;
  logic           accept;
  logic           is_digit, is_term, is_x;
  logic [3:0]     nib;

  // Character classification
  always_comb begin
    is_digit = 1'b1;
    nib      = 4'h0;
    if (bus.in_data >= "0" && bus.in_data <= "9") begin
      nib = 4'(bus.in_data - 8'h30);
    end else if (bus.in_data >= "A" && bus.in_data <= "F") begin
      nib = 4'(bus.in_data - 8'h37);
    end else if (bus.in_data >= "a" && bus.in_data <= "f") begin
      nib = 4'(bus.in_data - 8'h57);
    end else begin
      is_digit = 1'b0;
    end
    is_term = (bus.in_data == 8'h20) || (bus.in_data == 8'h0D) ||
              (bus.in_data == 8'h0A) || (bus.in_data == 8'h2C);
    is_x    = (bus.in_data == 8'h78) || (bus.in_data == 8'h58);
  end

  assign accept = bus.in_valid && in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      cnt_q    <= '0;
      pfx_q    <= 1'b0;
      err_q    <= 2'b00;
      odata_q  <= '0;
      ondig_q  <= '0;
      oerr_q   <= 2'b00;
      ovalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      pfx_q    <= pfx_d;
      err_q    <= err_d;
      odata_q  <= odata_d;
      ondig_q  <= ondig_d;
      oerr_q   <= oerr_d;
      ovalid_q <= ovalid_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    pfx_d    = pfx_q;
    err_d    = err_q;
    odata_d  = odata_q;
    ondig_d  = ondig_q;
    oerr_d   = oerr_q;
    ovalid_d = ovalid_q;
    unique case (state_q)
      StIdle, StAccum: begin
        if (accept) begin
          if (is_digit) begin
            if (cnt_q == NdigW) begin
              err_d   = 2'b10;
              state_d = StDiscard;
            end else begin
              acc_d      = acc_q << 4;
              acc_d[3:0] = nib;
              cnt_d      = cnt_q + 5'd1;
              state_d    = StAccum;
            end
          end else if (is_x && state_q == StAccum && cnt_q == 5'd1 &&
                       acc_q == '0 && !pfx_q) begin
            // The single leading '0' becomes the prefix, not a digit
            cnt_d = '0;
            pfx_d = 1'b1;
          end else if (is_term) begin
            if (state_q == StAccum) begin
              state_d  = StEmit;
              ovalid_d = 1'b1;
              if (cnt_q != '0) begin
                odata_d = acc_q;
                ondig_d = cnt_q;
                oerr_d  = 2'b00;
              end else begin
                odata_d = '0;
                ondig_d = '0;
                oerr_d  = 2'b11;
              end
            end
          end else begin
            err_d   = 2'b01;
            state_d = StDiscard;
          end
        end
      end
      StDiscard: begin
        if (accept && is_term) begin
          state_d  = StEmit;
          ovalid_d = 1'b1;
          odata_d  = '0;
          ondig_d  = '0;
          oerr_d   = err_q;
        end
      end
      StEmit: begin
        if (bus.out_ready) begin
          state_d  = StIdle;
          ovalid_d = 1'b0;
          acc_d    = '0;
          cnt_d    = '0;
          pfx_d    = 1'b0;
          err_d    = 2'b00;
          odata_d  = '0;
          ondig_d  = '0;
          oerr_d   = 2'b00;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: in_ready depends only on state and reset, never on out_ready
  always_comb begin
    in_ready      = rst_n && (state_q != StEmit);
    bus.in_ready  = in_ready;
    bus.out_data  = odata_q;
    bus.out_ndig  = ondig_q;
    bus.out_err   = oerr_q;
    bus.out_valid = ovalid_q;
  end
endmodule

// File: tb/tb_dc_ascii_hex_parser.sv
module tb_dc_ascii_hex_parser;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  dc_ascii_hex_parser_if #(.NDIG(8)) bus ();

  dc_ascii_hex_parser #(.NDIG(8)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one character and hold it until it is taken (bounded)
  task automatic send(input byte c);
    int n = 0;
    @(negedge clk);
    bus.in_data  = c;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("send_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  // Wait for a word, compare it, then consume it
  task automatic expect_word(input string tag, input logic [31:0] d, input logic [4:0] nd,
                             input logic [1:0] e);
    int n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, "_data"}, 64'(bus.out_data), 64'(d));
    chk({tag, "_ndig"}, 64'(bus.out_ndig), 64'(nd));
    chk({tag, "_err"}, 64'(bus.out_err), 64'(e));
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, "_drop"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    bus.in_data   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_out_ndig", 64'(bus.out_ndig), 64'd0);
    chk("rst_out_err", 64'(bus.out_err), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 64'(bus.in_ready), 64'd1);

    // Basic word with 1-cycle output latency
    send_str("1A3f");
    chk("w1_not_yet", 64'(bus.out_valid), 64'd0);
    send(8'h0D);
    chk("w1_latency", 64'(bus.out_valid), 64'd1);
    expect_word("w1", 32'h0000_1A3F, 5'd4, 2'b00);

    // Leading separators silent, prefix, prefix-only word
    send_str("  ");
    @(negedge clk);
    chk("lead_sp_silent", 64'(bus.out_valid), 64'd0);
    send_str("0x7E,");
    expect_word("w2", 32'h7E, 5'd2, 2'b00);
    send_str("0X ");
    expect_word("w3", 32'h0, 5'd0, 2'b11);

    // Overflow, then recovery
    send_str("123456789 ");
    expect_word("ovf", 32'h0, 5'd0, 2'b10);
    send_str("5\n");
    expect_word("w5", 32'h5, 5'd1, 2'b00);

    // Invalid characters, including a second prefix
    send_str("12G4 ");
    expect_word("inv_g", 32'h0, 5'd0, 2'b01);
    send_str("0x0x1 ");
    expect_word("inv_x", 32'h0, 5'd0, 2'b01);

    // Full 8-digit word is still legal
    send_str("FFFFFFFF ");
    expect_word("max", 32'hFFFF_FFFF, 5'd8, 2'b00);

    // Output stall: 'C' is offered throughout and must not be taken
    send_str("AB ");
    @(negedge clk);
    bus.in_data  = "C";
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
      chk("stall_valid", 64'(bus.out_valid), 64'd1);
      chk("stall_data", 64'(bus.out_data), 64'hAB);
      chk("stall_ndig", 64'(bus.out_ndig), 64'd2);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("xfer_drop", 64'(bus.out_valid), 64'd0);
    chk("xfer_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    send(8'h20);
    expect_word("after_stall", 32'hC, 5'd1, 2'b00);

    // Reset mid-word discards the partial word
    send_str("AB");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_ready_back", 64'(bus.in_ready), 64'd1);
    send_str("C ");
    expect_word("midrst", 32'hC, 5'd1, 2'b00);

    // Reset while a word is held drops it
    send_str("7 ");
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("emitrst_valid", 64'(bus.out_valid), 64'd0);
    chk("emitrst_data", 64'(bus.out_data), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dc_ascii_hex_parser.md
DC_ASCII_HEX_PARSER -- requirements
Module: DC_ASCII_HEX_PARSER

Interface
REQ-001 SHALL have parameter NDIG, default 8: maximum hex digits per word, legal range 1..16.
REQ-002 SHALL have port CLK, input, 1, the only clock; all state updates on rising edge.
REQ-003 SHALL have port RST_N, input, 1, reset: synchronous, active-low.
REQ-004 SHALL have port IN_DATA, input, 8, ASCII character.
REQ-005 SHALL have port IN_VALID, input, 1, IN_DATA valid.
REQ-006 SHALL have port IN_READY, output, 1, parser can accept a character.
REQ-007 SHALL have port OUT_DATA, output, 4*NDIG, parsed value, right-aligned, zero-extended.
REQ-008 SHALL have port OUT_NDIG, output, 5, number of digits in OUT_DATA.
REQ-009 SHALL have port OUT_ERR, output, 2: 00 ok, 01 invalid char, 10 overflow, 11 empty after prefix.
REQ-010 SHALL have port OUT_VALID, output, 1, word available.
REQ-011 SHALL have port OUT_READY, input, 1, consumer accepts word.

Function
REQ-012 SHALL transfer an input character on any cycle with IN_VALID=1 and IN_READY=1.
REQ-013 SHALL transfer an output word on any cycle with OUT_VALID=1 and OUT_READY=1.
REQ-014 SHALL implement states IDLE (no digits), ACCUM (digits or prefix pending), DISCARD (error latched), EMIT (word held).
REQ-015 SHALL drive IN_READY=1 in IDLE, ACCUM and DISCARD, and IN_READY=0 in EMIT and while RST_N=0.
REQ-016 SHALL classify '0'-'9', 'A'-'F' and 'a'-'f' as digits mapping to values 0x0-0xF, case-insensitive.
REQ-017 SHALL classify 0x20, 0x0D, 0x0A and 0x2C as terminators.
REQ-018 SHALL classify every other byte as invalid, except 'x'/'X' as governed by REQ-021.
REQ-019 SHALL, on digit acceptance with count<NDIG in IDLE or ACCUM, set acc=(acc<<4)|nibble, increment count, and enter ACCUM.
REQ-020 SHALL, on digit acceptance with count==NDIG, latch error 10 and enter DISCARD.
REQ-021 SHALL, on 'x'/'X' in ACCUM with count==1, acc==0 and no prefix seen, clear count, set prefix flag and stay in ACCUM.
REQ-022 SHALL treat any other 'x'/'X' as an invalid character.
REQ-023 SHALL, on an invalid character in IDLE or ACCUM, latch error 01 and enter DISCARD.
REQ-024 SHALL, in DISCARD, ignore digits and invalid characters and keep the first latched error code.
REQ-025 SHALL ignore terminators in IDLE: no empty words, so leading and repeated separators are silent.
REQ-026 SHALL, on a terminator in ACCUM with count>=1, enter EMIT with OUT_DATA=acc, OUT_NDIG=count, OUT_ERR=00.
REQ-027 SHALL, on a terminator in ACCUM with count==0 (prefix only), enter EMIT with OUT_ERR=11.
REQ-028 SHALL, on a terminator in DISCARD, enter EMIT with the latched OUT_ERR.
REQ-029 SHALL drive OUT_DATA=0 and OUT_NDIG=0 whenever OUT_ERR!=00.
REQ-030 SHALL register all outputs except IN_READY: terminator accepted at edge N gives OUT_VALID=1 after edge N, i.e. 1-cycle latency.
REQ-031 SHALL hold OUT_VALID, OUT_DATA, OUT_NDIG and OUT_ERR stable in EMIT until OUT_READY=1.
REQ-032 SHALL, on output transfer, clear acc, count, prefix flag and error, drop OUT_VALID, and return to IDLE on the next cycle.
REQ-033 SHALL accept no input character on the transfer cycle: IN_READY stays 0 throughout EMIT.
REQ-034 SHALL permit OUT_READY to be high before OUT_VALID, with no combinational path from OUT_READY to IN_READY.

Reset
REQ-035 SHALL, on a rising edge with RST_N=0, enter IDLE and clear acc, count, prefix flag and error.
REQ-036 SHALL, on that reset, drive OUT_VALID=0, OUT_DATA=0, OUT_NDIG=0 and OUT_ERR=00.
REQ-037 SHALL, on reset mid-word or in EMIT, discard the partial or pending word with no output.
REQ-038 SHALL accept a character on the first cycle after RST_N returns high.

Verification
REQ-039 SHALL pass: NDIG=8, stream "1A3f\r" -> one word OUT_DATA=0x00001A3F, OUT_NDIG=4, OUT_ERR=00, OUT_VALID one cycle after the '\r' accept.
REQ-040 SHALL pass: stream "  0x7E,0X " -> words {0x7E, NDIG=2, ERR=00} then {0, 0, ERR=11}, with the leading spaces producing nothing.
REQ-041 SHALL pass: NDIG=8, stream "123456789 " -> single word ERR=10, DATA=0; a following "5\n" gives 0x5, NDIG=1.
REQ-042 SHALL pass: stream "12G4 " -> single word ERR=01; stream "0x0x1 " -> ERR=01.
REQ-043 SHALL pass: OUT_READY held 0 for 5 cycles after "AB " -> IN_READY=0 and outputs stable for the full stall; transfer on OUT_READY=1; next character accepted 1 cycle later.
REQ-044 SHALL pass: "AB", then RST_N=0 for 1 cycle, then "C " -> only word 0xC, NDIG=1; "AB" is never emitted.
